// File: rtl/kmeans_pkg.sv
// kmeans_pkg: shared widths, base addresses, engine state encoding and
// the saturating square-accumulate used by the distance engine.
package kmeans_pkg;

    localparam int IO_ADDR_W_DEF   = 14;
    localparam int IO_WORD_W_DEF   = 16;
    localparam int DC_ADDR_W_DEF   = 14;
    localparam int DC_WORD_W_DEF   = 32;
    localparam int NUM_W_DEF       = 16;
    localparam int CENT_BASE_DEF   = 12288;
    localparam int ASSIGN_BASE_DEF = 14336;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_PT,
        S_RD_CENT,
        S_ACCUM,
        S_WR_DIST,
        S_SCAN,
        S_WR_ASSIGN,
        S_DONE
    } state_t;

    // acc + (x - c)^2, clamped to 2^w - 1. Operands arrive sign-extended
    // to 32 bits so the difference never wraps.
    function automatic logic [63:0] sq_acc_sat(
        input logic [63:0]        acc,
        input logic signed [31:0] x,
        input logic signed [31:0] c,
        input int                 w
    );
        logic signed [32:0] diff;
        logic [32:0]        mag;
        logic [65:0]        sq;
        logic [66:0]        sum;
        logic [66:0]        lim;
        diff = 33'(x) - 33'(c);
        mag  = diff[32] ? 33'(-diff) : 33'(diff);
        sq   = 66'(mag) * 66'(mag);
        sum  = 67'(acc) + 67'(sq);
        lim  = (67'(1) << w) - 67'(1);
        return (sum > lim) ? lim[63:0] : sum[63:0];
    endfunction

endpackage

// File: rtl/calc_all_distances_if.sv
// calc_all_distances_if: IO and DC BRAM port bundle.
// master = engine side (drives addr/dout/we), slave = memory side (drives din).
interface calc_all_distances_if
    import kmeans_pkg::*;
#(
    parameter int IO_ADDR_W = IO_ADDR_W_DEF,
    parameter int IO_WORD_W = IO_WORD_W_DEF,
    parameter int DC_ADDR_W = DC_ADDR_W_DEF,
    parameter int DC_WORD_W = DC_WORD_W_DEF
);
    logic [IO_ADDR_W-1:0] io_bram_addr_o;
    logic [IO_WORD_W-1:0] io_bram_dout_o;
    logic [IO_WORD_W-1:0] io_bram_din_i;
    logic                 io_bram_we_o;
    logic [DC_ADDR_W-1:0] dc_bram_addr_o;
    logic [DC_WORD_W-1:0] dc_bram_dout_o;
    logic [DC_WORD_W-1:0] dc_bram_din_i;
    logic                 dc_bram_we_o;

    modport master (
        output io_bram_addr_o, io_bram_dout_o, io_bram_we_o,
        output dc_bram_addr_o, dc_bram_dout_o, dc_bram_we_o,
        input  io_bram_din_i, dc_bram_din_i
    );

    modport slave (
        input  io_bram_addr_o, io_bram_dout_o, io_bram_we_o,
        input  dc_bram_addr_o, dc_bram_dout_o, dc_bram_we_o,
        output io_bram_din_i, dc_bram_din_i
    );
endinterface

// File: rtl/min_index_scan.sv
// min_index_scan: running minimum over a streamed distance row; i_last
// closes a row so the next valid starts fresh at index 0.
// Ports: i_clk, i_rst_n, i_valid, i_last, i_dist -> o_min, o_idx.
// Built only with CLOSEST_CENTROID_EN.
`ifdef CLOSEST_CENTROID_EN
module min_index_scan
    import kmeans_pkg::*;
#(
    parameter int DW = DC_WORD_W_DEF,
    parameter int IW = NUM_W_DEF
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_valid,
    input  logic          i_last,
    input  logic [DW-1:0] i_dist,
    output logic [DW-1:0] o_min,
    output logic [IW-1:0] o_idx
);
    logic [DW-1:0] r_min;
    logic [IW-1:0] r_idx;
    logic [IW-1:0] r_cnt;
    logic          r_fresh;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_min   <= '0;
            r_idx   <= '0;
            r_cnt   <= '0;
            r_fresh <= 1'b1;
        end else if (i_valid) begin
            // strict less-than: ties keep the earlier index
            if (r_fresh || (i_dist < r_min)) begin
                r_min <= i_dist;
                r_idx <= r_cnt;
            end
            r_cnt   <= i_last ? '0 : r_cnt + IW'(1);
            r_fresh <= i_last;
        end
    end

    assign o_min = r_min;
    assign o_idx = r_idx;
endmodule
`endif

// File: rtl/calc_all_distances.sv
// calc_all_distances: squared distance of every point to every centroid
// (IO BRAM -> DC BRAM); with CLOSEST_CENTROID_EN also writes each point's
// nearest-centroid index back to the IO BRAM.
// Ports: clk_i, reset_i (async, active-low), start_i, ready_o, err_o,
// num_vals_i/num_clusters_i/num_dims_i, bram (BRAM master side).
module calc_all_distances
    import kmeans_pkg::*;
#(
    parameter int IO_ADDR_W   = IO_ADDR_W_DEF,
    parameter int IO_WORD_W   = IO_WORD_W_DEF,
    parameter int DC_ADDR_W   = DC_ADDR_W_DEF,
    parameter int DC_WORD_W   = DC_WORD_W_DEF,
    parameter int NUM_W       = NUM_W_DEF,
    parameter int CENT_BASE   = CENT_BASE_DEF,
    parameter int ASSIGN_BASE = ASSIGN_BASE_DEF
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             start_i,
    output logic             ready_o,
    output logic             err_o,
    input  logic [NUM_W-1:0] num_vals_i,
    input  logic [NUM_W-1:0] num_clusters_i,
    input  logic [NUM_W-1:0] num_dims_i,
    calc_all_distances_if.master bram
);
    localparam int MW = 2 * NUM_W;

    state_t                 r_state;
    logic [NUM_W-1:0]       r_v, r_k, r_dd;
    logic [NUM_W-1:0]       r_p, r_c, r_d;
    logic [DC_WORD_W-1:0]   r_acc;
    logic signed [IO_WORD_W-1:0] r_x;

    logic signed [IO_WORD_W-1:0] w_cent;
    logic [DC_WORD_W-1:0]   w_acc_nx;
    logic [MW-1:0]          w_vk;
    logic                   w_bad;
    logic                   w_last_d, w_last_c, w_last_p;
    logic [IO_ADDR_W-1:0]   w_pt_addr, w_ct_addr;
    logic [DC_ADDR_W-1:0]   w_dc_addr;

    assign w_vk  = MW'(num_vals_i) * MW'(num_clusters_i);
    assign w_bad = (num_vals_i == '0) || (num_clusters_i == '0)
                || (num_dims_i == '0)
                || ((MW+1)'(w_vk) > ((MW+1)'(1) << DC_ADDR_W));

    assign w_cent   = bram.io_bram_din_i;
    assign w_acc_nx = DC_WORD_W'(sq_acc_sat(64'(r_acc), 32'(r_x),
                                            32'(w_cent), DC_WORD_W));

    assign w_last_d = (r_d == r_dd - NUM_W'(1));
    assign w_last_c = (r_c == r_k - NUM_W'(1));
    assign w_last_p = (r_p == r_v - NUM_W'(1));

    assign w_pt_addr = IO_ADDR_W'(r_p) * IO_ADDR_W'(r_dd) + IO_ADDR_W'(r_d);
    assign w_ct_addr = IO_ADDR_W'(CENT_BASE)
                     + IO_ADDR_W'(r_c) * IO_ADDR_W'(r_dd) + IO_ADDR_W'(r_d);
    assign w_dc_addr = DC_ADDR_W'(r_p) * DC_ADDR_W'(r_k) + DC_ADDR_W'(r_c);

`ifdef CLOSEST_CENTROID_EN
    logic             r_sc_vld;
    logic             r_sc_last;
    logic             w_scan_rd;
    logic [NUM_W-1:0] w_idx;

    // SCAN spends K cycles issuing reads, one more to fold the last datum
    assign w_scan_rd = (r_state == S_SCAN) && (r_c != r_k);

    min_index_scan #(
        .DW (DC_WORD_W),
        .IW (NUM_W)
    ) u_scan (
        .i_clk   (clk_i),
        .i_rst_n (reset_i),
        .i_valid (r_sc_vld),
        .i_last  (r_sc_last),
        .i_dist  (bram.dc_bram_din_i),
        .o_min   (),
        .o_idx   (w_idx)
    );
`endif

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_state <= S_IDLE;
            ready_o <= 1'b1;
            err_o   <= 1'b0;
            r_v     <= '0;
            r_k     <= '0;
            r_dd    <= '0;
            r_p     <= '0;
            r_c     <= '0;
            r_d     <= '0;
            r_acc   <= '0;
            r_x     <= '0;
`ifdef CLOSEST_CENTROID_EN
            r_sc_vld  <= 1'b0;
            r_sc_last <= 1'b0;
`endif
        end else begin
`ifdef CLOSEST_CENTROID_EN
            r_sc_vld  <= 1'b0;
            r_sc_last <= 1'b0;
`endif
            unique case (r_state)
                S_IDLE: begin
                    // ready_o only rises one IDLE cycle after DONE, so
                    // a start seen in that cycle is not accepted
                    if (start_i && ready_o) begin
                        ready_o <= 1'b0;
                        if (w_bad) begin
                            err_o   <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            err_o   <= 1'b0;
                            r_v     <= num_vals_i;
                            r_k     <= num_clusters_i;
                            r_dd    <= num_dims_i;
                            r_p     <= '0;
                            r_c     <= '0;
                            r_d     <= '0;
                            r_acc   <= '0;
                            r_state <= S_RD_PT;
                        end
                    end else begin
                        ready_o <= 1'b1;
                    end
                end
                S_RD_PT: r_state <= S_RD_CENT;
                S_RD_CENT: begin
                    r_x     <= bram.io_bram_din_i;
                    r_state <= S_ACCUM;
                end
                S_ACCUM: begin
                    r_acc <= w_acc_nx;
                    if (w_last_d) begin
                        r_d     <= '0;
                        r_state <= S_WR_DIST;
                    end else begin
                        r_d     <= r_d + NUM_W'(1);
                        r_state <= S_RD_PT;
                    end
                end
                S_WR_DIST: begin
                    r_acc <= '0;
                    if (!w_last_c) begin
                        r_c     <= r_c + NUM_W'(1);
                        r_state <= S_RD_PT;
                    end else if (!w_last_p) begin
                        r_c     <= '0;
                        r_p     <= r_p + NUM_W'(1);
                        r_state <= S_RD_PT;
                    end else begin
                        r_c     <= '0;
                        r_p     <= '0;
`ifdef CLOSEST_CENTROID_EN
                        r_state <= S_SCAN;
`else
                        r_state <= S_DONE;
`endif
                    end
                end
`ifdef CLOSEST_CENTROID_EN
                S_SCAN: begin
                    if (r_c == r_k) begin
                        r_c     <= '0;
                        r_state <= S_WR_ASSIGN;
                    end else begin
                        r_sc_vld  <= 1'b1;
                        r_sc_last <= w_last_c;
                        r_c       <= r_c + NUM_W'(1);
                    end
                end
                S_WR_ASSIGN: begin
                    if (w_last_p) begin
                        r_p     <= '0;
                        r_state <= S_DONE;
                    end else begin
                        r_p     <= r_p + NUM_W'(1);
                        r_state <= S_SCAN;
                    end
                end
`endif
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // BRAM ports are a pure decode of registered state; all zero when idle
    always_comb begin
        bram.io_bram_addr_o = '0;
        bram.io_bram_dout_o = '0;
        bram.io_bram_we_o   = 1'b0;
        bram.dc_bram_addr_o = '0;
        bram.dc_bram_dout_o = '0;
        bram.dc_bram_we_o   = 1'b0;
        unique case (1'b1)
            (r_state == S_RD_PT): bram.io_bram_addr_o = w_pt_addr;
            (r_state == S_RD_CENT): bram.io_bram_addr_o = w_ct_addr;
            (r_state == S_WR_DIST): begin
                bram.dc_bram_addr_o = w_dc_addr;
                bram.dc_bram_dout_o = r_acc;
                bram.dc_bram_we_o   = 1'b1;
            end
`ifdef CLOSEST_CENTROID_EN
            w_scan_rd: bram.dc_bram_addr_o = w_dc_addr;
            (r_state == S_WR_ASSIGN): begin
                bram.io_bram_addr_o = IO_ADDR_W'(ASSIGN_BASE)
                                    + IO_ADDR_W'(r_p);
                bram.io_bram_dout_o = IO_WORD_W'(w_idx);
                bram.io_bram_we_o   = 1'b1;
            end
`endif
            default: ;
        endcase
    end
endmodule

// File: tb/tb_calc_all_distances.sv
// tb_calc_all_distances: directed bench for calc_all_distances with
// behavioural 1-cycle-latency IO and DC BRAMs.
module tb_calc_all_distances;
    import kmeans_pkg::*;

    localparam int CB = CENT_BASE_DEF;
    localparam int AB = ASSIGN_BASE_DEF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] nv = '0, nk = '0, nd = '0;
    logic        ready, err;
    int          checks = 0;
    int          errors = 0;
    int          lat;

    logic [15:0] io_mem [0:16383];
    logic [31:0] dc_mem [0:16383];
    logic [13:0] dcw_a[$];
    logic [31:0] dcw_d[$];
    logic [13:0] iow_a[$];
    logic [15:0] iow_d[$];

    calc_all_distances_if bus();

    calc_all_distances dut (
        .clk_i          (clk),
        .reset_i        (rst_n),
        .start_i        (start),
        .ready_o        (ready),
        .err_o          (err),
        .num_vals_i     (nv),
        .num_clusters_i (nk),
        .num_dims_i     (nd),
        .bram           (bus.master)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        bus.io_bram_din_i <= io_mem[bus.io_bram_addr_o];
        bus.dc_bram_din_i <= dc_mem[bus.dc_bram_addr_o];
        if (bus.io_bram_we_o) begin
            io_mem[bus.io_bram_addr_o] <= bus.io_bram_dout_o;
            iow_a.push_back(bus.io_bram_addr_o);
            iow_d.push_back(bus.io_bram_dout_o);
        end
        if (bus.dc_bram_we_o) begin
            dc_mem[bus.dc_bram_addr_o] <= bus.dc_bram_dout_o;
            dcw_a.push_back(bus.dc_bram_addr_o);
            dcw_d.push_back(bus.dc_bram_dout_o);
        end
    end

    task automatic start_job(input int v, input int k, input int d);
        nv = 16'(v);
        nk = 16'(k);
        nd = 16'(d);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // counts sampled cycles with ready_o low; optional busy start pulses
    task automatic wait_ready(input bit poke, output int n);
        n = 0;
        while (ready !== 1'b1 && n < 2000) begin
            n++;
            start = poke && (n % 7 == 3);
            @(negedge clk);
        end
        start = 1'b0;
        if (n >= 2000) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: got ready=%b after %0d cycles", ready, n);
        end
    endtask

    task automatic load_scenario1();
        io_mem[0] = 16'd1;  io_mem[1] = 16'd2;
        io_mem[2] = 16'd10; io_mem[3] = 16'd10;
        io_mem[CB]   = 16'd0;  io_mem[CB+1] = 16'd0;
        io_mem[CB+2] = 16'd10; io_mem[CB+3] = 16'd9;
        io_mem[AB] = 16'hFFFF; io_mem[AB+1] = 16'hFFFF;
        for (int i = 0; i < 4; i++) dc_mem[i] = 32'hDEADBEEF;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (ready !== 1'b1 || err !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: got ready=%b err=%b expected 1 0", ready, err);
        end
        checks++;
        if (bus.io_bram_we_o !== 1'b0 || bus.dc_bram_we_o !== 1'b0 ||
            bus.io_bram_addr_o !== 14'd0 || bus.dc_bram_addr_o !== 14'd0) begin
            errors++;
            $display("FAIL reset_bus: got iowe=%b dcwe=%b ioa=%0d dca=%0d expected 0",
                     bus.io_bram_we_o, bus.dc_bram_we_o,
                     bus.io_bram_addr_o, bus.dc_bram_addr_o);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_distances(input bit poke, input string tag);
        logic [31:0] exp_d [4];
        int          b, ib, exp_lat;
        exp_d = '{32'd5, 32'd130, 32'd200, 32'd1};
`ifdef CLOSEST_CENTROID_EN
        exp_lat = 38;
`else
        exp_lat = 30;
`endif
        load_scenario1();
        b  = dcw_a.size();
        ib = iow_a.size();
        start_job(2, 2, 2);
        wait_ready(poke, lat);
        checks++;
        if (lat != exp_lat) begin
            errors++;
            $display("FAIL %s_latency: got %0d expected %0d", tag, lat, exp_lat);
        end
        checks++;
        if (dcw_a.size() - b != 4) begin
            errors++;
            $display("FAIL %s_dc_count: got %0d expected 4", tag, dcw_a.size() - b);
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (dcw_a[b+i] !== 14'(i) || dcw_d[b+i] !== exp_d[i]) begin
                    errors++;
                    $display("FAIL %s_dc_write%0d: got addr %0d data %0d expected addr %0d data %0d",
                             tag, i, dcw_a[b+i], dcw_d[b+i], i, exp_d[i]);
                end
            end
        end
`ifdef CLOSEST_CENTROID_EN
        checks++;
        if (io_mem[AB] !== 16'd0 || io_mem[AB+1] !== 16'd1 || iow_a.size() - ib != 2) begin
            errors++;
            $display("FAIL %s_assign: got %0d %0d (%0d writes) expected 0 1 (2 writes)",
                     tag, io_mem[AB], io_mem[AB+1], iow_a.size() - ib);
        end
`else
        checks++;
        if (iow_a.size() - ib != 0) begin
            errors++;
            $display("FAIL %s_io_writes: got %0d expected 0", tag, iow_a.size() - ib);
        end
`endif
    endtask

    task automatic load_tie();
        io_mem[0] = 16'd5;
        io_mem[CB] = 16'd3; io_mem[CB+1] = 16'd7; io_mem[CB+2] = 16'd9;
        io_mem[AB] = 16'hFFFF;
        for (int i = 0; i < 3; i++) dc_mem[i] = 32'hDEADBEEF;
    endtask

    task automatic test_tie();
        int exp_lat;
`ifdef CLOSEST_CENTROID_EN
        exp_lat = 19;
`else
        exp_lat = 14;
`endif
        load_tie();
        start_job(1, 3, 1);
        wait_ready(1'b0, lat);
        checks++;
        if (lat != exp_lat) begin
            errors++;
            $display("FAIL tie_latency: got %0d expected %0d", lat, exp_lat);
        end
        checks++;
        if (dc_mem[0] !== 32'd4 || dc_mem[1] !== 32'd4 || dc_mem[2] !== 32'd16) begin
            errors++;
            $display("FAIL tie_dist: got %0d %0d %0d expected 4 4 16",
                     dc_mem[0], dc_mem[1], dc_mem[2]);
        end
`ifdef CLOSEST_CENTROID_EN
        checks++;
        if (io_mem[AB] !== 16'd0) begin
            errors++;
            $display("FAIL tie_assign: got %0d expected 0", io_mem[AB]);
        end
`endif
    endtask

    task automatic test_saturation();
        io_mem[0] = 16'h8000;
        io_mem[CB] = 16'h7FFF;
        dc_mem[0] = 32'd0;
        start_job(1, 1, 1);
        wait_ready(1'b0, lat);
        checks++;
        if (dc_mem[0] !== 32'd4294836225) begin
            errors++;
            $display("FAIL sat_d1: got %0d expected 4294836225", dc_mem[0]);
        end
        io_mem[1] = 16'h8000;
        io_mem[CB+1] = 16'h7FFF;
        dc_mem[0] = 32'd0;
        start_job(1, 1, 2);
        wait_ready(1'b0, lat);
        checks++;
        if (dc_mem[0] !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL sat_d2: got %0d expected 4294967295", dc_mem[0]);
        end
    endtask

    task automatic test_zero_counts();
        int b, ib;
        b  = dcw_a.size();
        ib = iow_a.size();
        start_job(2, 2, 0);
        wait_ready(1'b0, lat);
        checks++;
        if (lat != 2 || err !== 1'b1) begin
            errors++;
            $display("FAIL zero_dims: got low=%0d err=%b expected 2 1", lat, err);
        end
        start_job(129, 128, 1);
        wait_ready(1'b0, lat);
        checks++;
        if (lat != 2 || err !== 1'b1) begin
            errors++;
            $display("FAIL vk_overflow: got low=%0d err=%b expected 2 1", lat, err);
        end
        checks++;
        if (dcw_a.size() != b || iow_a.size() != ib) begin
            errors++;
            $display("FAIL err_writes: got %0d dc %0d io expected 0 0",
                     dcw_a.size() - b, iow_a.size() - ib);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL err_hold: got %b expected 1", err);
        end
        load_tie();
        start_job(1, 3, 1);
        wait_ready(1'b0, lat);
        checks++;
        if (err !== 1'b0 || dc_mem[2] !== 32'd16) begin
            errors++;
            $display("FAIL err_clear: got err=%b dc2=%0d expected 0 16", err, dc_mem[2]);
        end
    endtask

    task automatic test_reset_mid();
        load_scenario1();
        start_job(2, 2, 2);
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (ready !== 1'b1 || err !== 1'b0 ||
            bus.io_bram_we_o !== 1'b0 || bus.dc_bram_we_o !== 1'b0 ||
            bus.io_bram_addr_o !== 14'd0 || bus.dc_bram_addr_o !== 14'd0) begin
            errors++;
            $display("FAIL reset_mid: got ready=%b err=%b iowe=%b dcwe=%b ioa=%0d dca=%0d expected 1 0 0 0 0 0",
                     ready, err, bus.io_bram_we_o, bus.dc_bram_we_o,
                     bus.io_bram_addr_o, bus.dc_bram_addr_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_distances(1'b0, "dist");
        test_tie();
        test_saturation();
        test_zero_counts();
        test_reset_mid();
        test_distances(1'b1, "busy_start");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
